vec_csr_unit: RTL and testbench

VEC_CSR_UNIT -- requirements
Module: vec_csr_unit

---
 rtl/vec_csr_unit_pkg.sv | 10 +
 rtl/vec_csr_unit_if.sv | 17 +
 rtl/vec_vlmax_calc.sv | 15 +
 rtl/vec_csr_unit.sv | 75 +++++++
 tb/tb_vec_csr_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/vec_csr_unit_pkg.sv
// vec_csr_unit_pkg: shared vset op/state encodings, default sizes and vill position
package vec_csr_unit_pkg;
  localparam int VLEN_DEF = 512;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {VSETVLI = 2'd0, VSETIVLI = 2'd1, VSETVL = 2'd2, VSET_ILL = 2'd3} vset_op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_e;
  function automatic int vill_bit(int xlen);
    return xlen - 1;
  endfunction
endpackage

// File: rtl/vec_csr_unit_if.sv
// vec_csr_unit_if: vset request/response handshake between decode and the CSR unit
interface vec_csr_unit_if import vec_csr_unit_pkg::*; #(parameter int XLEN = XLEN_DEF);
  logic req_valid;
  logic req_ready;
  vset_op_e req_op;
  logic [XLEN-1:0] scalar1;
  logic [XLEN-1:0] scalar2;
  logic rs1_is_x0;
  logic rd_is_x0;
  logic rsp_valid;
  logic rsp_ready;
  logic [XLEN-1:0] rsp_vl;
  modport master (output req_valid, req_op, scalar1, scalar2, rs1_is_x0, rd_is_x0, rsp_ready,
                  input req_ready, rsp_valid, rsp_vl);
  modport slave (input req_valid, req_op, scalar1, scalar2, rs1_is_x0, rd_is_x0, rsp_ready,
                 output req_ready, rsp_valid, rsp_vl);
endinterface

// File: rtl/vec_vlmax_calc.sv
// vec_vlmax_calc: combinational VLMAX and vtype legality from the vtype fields
module vec_vlmax_calc import vec_csr_unit_pkg::*; #(
  parameter int VLEN = VLEN_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  vset_op_e        op,
  input  logic [2:0]      vsew,
  input  logic [2:0]      vlmul,
  input  logic            rsvd_nz,
  output logic [XLEN-1:0] vlmax,
  output logic            legal
);
  assign legal = op != VSET_ILL && vsew <= 3'd2 && !vlmul[2] && !rsvd_nz;
  assign vlmax = XLEN'(VLEN >> (3 + int'(vsew))) << vlmul[1:0];
endmodule

// File: rtl/vec_csr_unit.sv
// vec_csr_unit: vsetvl/vsetvli/vsetivli execution and vl/vtype/vstart CSR state
module vec_csr_unit import vec_csr_unit_pkg::*; #(
  parameter int VLEN = VLEN_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  vec_csr_unit_if.slave   bus,
  output logic [XLEN-1:0] csr_vl,
  output logic [XLEN-1:0] csr_vtype,
  output logic [XLEN-1:0] csr_vstart,
  input  logic            vstart_we,
  input  logic [XLEN-1:0] vstart_wdata
);
  localparam logic [XLEN-1:0] VILL = XLEN'(1) << vill_bit(XLEN);
  state_e state, next_state;
  vset_op_e op_q;
  logic [XLEN-1:0] s1_q, s2_q, vlmax, new_vl, rsp_vl_q;
  logic rs1_x0_q, rd_x0_q, legal;
  function automatic logic [XLEN-1:0] umin(logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    return a < b ? a : b;
  endfunction
  vec_vlmax_calc #(.VLEN(VLEN), .XLEN(XLEN)) u_calc (
    .op(op_q),
    .vsew(s2_q[5:3]),
    .vlmul(s2_q[2:0]),
    .rsvd_nz(|s2_q[XLEN-1:8]),
    .vlmax(vlmax),
    .legal(legal)
  );
  always_comb begin
    next_state = state;
    new_vl = '0;
    next_state = state == IDLE ? (bus.req_valid ? CALC : IDLE) :
                 state == CALC ? RESP : (bus.rsp_ready ? IDLE : RESP);
    new_vl = !legal ? '0 :
             op_q == VSETIVLI ? umin({{(XLEN-5){1'b0}}, s1_q[4:0]}, vlmax) :
             rs1_x0_q && !rd_x0_q ? vlmax :
             rs1_x0_q ? umin(csr_vl, vlmax) : umin(s1_q, vlmax);
  end
  assign bus.req_ready = reset_n && state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_vl = rsp_vl_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op_q <= VSETVLI;
      s1_q <= '0;
      s2_q <= '0;
      rs1_x0_q <= 1'b0;
      rd_x0_q <= 1'b0;
      rsp_vl_q <= '0;
      csr_vl <= '0;
      csr_vtype <= VILL;
      csr_vstart <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.req_valid) begin
        op_q <= bus.req_op;
        s1_q <= bus.scalar1;
        s2_q <= bus.scalar2;
        rs1_x0_q <= bus.rs1_is_x0;
        rd_x0_q <= bus.rd_is_x0;
      end
      if (state == CALC) begin
        rsp_vl_q <= new_vl;
        csr_vl <= new_vl;
        csr_vtype <= legal ? {{(XLEN-8){1'b0}}, s2_q[7:0]} : VILL;
        csr_vstart <= '0;
      end else if (vstart_we) begin
        csr_vstart <= vstart_wdata;
      end
    end
  end
endmodule

// File: tb/tb_vec_csr_unit.sv
// tb_vec_csr_unit: directed and randomized vset checks against a rule-level reference model
module tb_vec_csr_unit;
  import vec_csr_unit_pkg::*;
  localparam int VLEN = 512;
  localparam int XLEN = 32;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic vstart_we = 1'b0;
  logic [31:0] vstart_wdata = '0;
  logic [31:0] csr_vl, csr_vtype, csr_vstart;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_vl, m_vtype, m_vstart;
  always #5 clk = ~clk;
  vec_csr_unit_if #(.XLEN(XLEN)) bus ();
  vec_csr_unit #(.VLEN(VLEN), .XLEN(XLEN)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .csr_vl(csr_vl),
    .csr_vtype(csr_vtype),
    .csr_vstart(csr_vstart),
    .vstart_we(vstart_we),
    .vstart_wdata(vstart_wdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic longint mn(longint a, longint b);
    return a < b ? a : b;
  endfunction
  // Architectural rules: SEW = 8<<vsew, LMUL = 1<<vlmul, VLMAX = VLEN*LMUL/SEW
  function automatic void model(int op, logic [31:0] s1, logic [31:0] s2, bit rs1x0, bit rdx0);
    int sew_f = int'(s2[5:3]);
    int lm_f = int'(s2[2:0]);
    bit ok = op != 3 && sew_f <= 2 && lm_f <= 3 && s2[31:8] == 24'h0;
    longint vlmax = longint'(VLEN) * (longint'(1) << lm_f) / (longint'(8) << sew_f);
    longint vl;
    if (!ok) begin
      vl = 0;
      m_vtype = 32'h8000_0000;
    end else begin
      if (op == 1) vl = mn(longint'(s1 % 32), vlmax);
      else if (rs1x0 && !rdx0) vl = vlmax;
      else if (rs1x0) vl = mn(longint'(m_vl), vlmax);
      else vl = mn(longint'(s1), vlmax);
      m_vtype = s2 & 32'hFF;
    end
    m_vl = 32'(vl);
    m_vstart = 0;
  endfunction
  task automatic model_reset();
    m_vl = 0;
    m_vtype = 32'h8000_0000;
    m_vstart = 0;
  endtask
  task automatic vset(input int op, input logic [31:0] s1, input logic [31:0] s2,
                      input bit rs1x0, input bit rdx0, input int hold, input bit clash);
    chk("req_ready_idle", {31'b0, bus.req_ready}, 1);
    bus.req_op = vset_op_e'(op[1:0]);
    bus.scalar1 = s1;
    bus.scalar2 = s2;
    bus.rs1_is_x0 = rs1x0;
    bus.rd_is_x0 = rdx0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.scalar1 = $urandom;
    bus.scalar2 = $urandom;
    model(op, s1, s2, rs1x0, rdx0);
    chk("calc_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    chk("calc_req_ready", {31'b0, bus.req_ready}, 0);
    if (clash) begin
      vstart_we = 1'b1;
      vstart_wdata = $urandom | 32'h1;
    end
    tick();
    vstart_we = 1'b0;
    chk("resp_valid", {31'b0, bus.rsp_valid}, 1);
    chk("rsp_vl", bus.rsp_vl, m_vl);
    chk("csr_vl", csr_vl, m_vl);
    chk("csr_vtype", csr_vtype, m_vtype);
    chk("csr_vstart_clr", csr_vstart, m_vstart);
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op = vset_op_e'(2'($urandom));
      bus.scalar1 = $urandom;
      bus.scalar2 = $urandom;
      tick();
      chk("hold_rsp_valid", {31'b0, bus.rsp_valid}, 1);
      chk("hold_rsp_vl", bus.rsp_vl, m_vl);
      chk("hold_req_ready", {31'b0, bus.req_ready}, 0);
      chk("hold_csr_vtype", csr_vtype, m_vtype);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("back_idle_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    chk("back_idle_csr_vl", csr_vl, m_vl);
  endtask
  task automatic vstart_write(input logic [31:0] d);
    vstart_we = 1'b1;
    vstart_wdata = d;
    tick();
    vstart_we = 1'b0;
    m_vstart = d;
    chk("vstart_write", csr_vstart, m_vstart);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = VSETVLI;
    bus.scalar1 = '0;
    bus.scalar2 = '0;
    bus.rs1_is_x0 = 1'b0;
    bus.rd_is_x0 = 1'b0;
    bus.rsp_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    chk("rst_rsp_vl", bus.rsp_vl, 0);
    chk("rst_csr_vl", csr_vl, 0);
    chk("rst_csr_vtype", csr_vtype, 32'h8000_0000);
    chk("rst_csr_vstart", csr_vstart, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();
    model_reset();
    chk("post_rst_req_ready", {31'b0, bus.req_ready}, 1);
    chk("post_rst_csr_vtype", csr_vtype, 32'h8000_0000);
    vstart_write(32'd7);
    vset(0, 32'd100, 32'h08, 0, 0, 0, 0);
    chk("sew16_lmul1_vl", csr_vl, 32'd32);
    vset(0, 32'd3, 32'h03, 1, 0, 3, 1);
    chk("vlmax_512", bus.rsp_vl, 32'd512);
    vset(0, 32'd999, 32'h10, 1, 1, 0, 0);
    chk("keep_vl_clamped", csr_vl, 32'd16);
    vset(2, 32'd5, 32'h05, 0, 0, 1, 0);
    chk("frac_lmul_vill", csr_vtype, 32'h8000_0000);
    chk("frac_lmul_vl", csr_vl, 32'd0);
    vset(1, 32'h3F, 32'h00, 0, 0, 0, 0);
    chk("ivli_uimm", csr_vl, 32'd31);
    vset(0, 32'hFFFF_FFFF, 32'hD1, 0, 0, 0, 0);
    chk("vta_vma_kept", csr_vtype, 32'hD1);
    vset(2, 32'd10, 32'h100, 0, 0, 0, 0);
    vset(3, 32'd10, 32'h00, 0, 0, 0, 0);
    vset(0, 32'd10, 32'h18, 0, 0, 0, 0);
    vset(0, 32'd10, 32'h04, 0, 0, 0, 0);
    vstart_write(32'hABCD);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] s1, s2;
      s1 = $urandom_range(0, 1) != 0 ? 32'($urandom_range(0, 600)) : $urandom;
      s2 = {($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'h0, 2'($urandom),
            3'($urandom_range(0, 3)), 3'($urandom)};
      if ($urandom_range(0, 3) == 0) vstart_write($urandom);
      vset(int'($urandom_range(0, 3)), s1, s2, 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 2)), 1'($urandom));
    end
    vset(0, 32'd40, 32'h00, 0, 0, 0, 0);
    bus.req_op = VSETVLI;
    bus.scalar1 = 32'd5;
    bus.scalar2 = 32'h01;
    bus.rs1_is_x0 = 1'b0;
    bus.rd_is_x0 = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("abort_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    chk("abort_req_ready", {31'b0, bus.req_ready}, 0);
    chk("abort_csr_vl", csr_vl, 0);
    chk("abort_csr_vtype", csr_vtype, 32'h8000_0000);
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk("abort_idle_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    tick();
    chk("abort_no_rsp", {31'b0, bus.rsp_valid}, 0);
    chk("abort_csr_vl_kept", csr_vl, 0);
    chk("abort_csr_vstart", csr_vstart, 0);
    vset(0, 32'd100, 32'h08, 0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
